// File: rtl/pll_seq_ctrl.sv
// pll_seq_ctrl: brings the PLL up, supervises lock with timeout/retries, re-sequences on divider change or lock loss
module pll_seq_ctrl #(
    parameter int OFF_CYCLES = 4,
    parameter int LOCK_TIMEOUT = 2000,
    parameter int RETRY_MAX = 2,
    parameter logic [7:0] FBDIV_RESET = 8'd8
) (
    input  logic       rclk,
    input  logic       rst,
    input  logic       start,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_fbdiv,
    output logic       cfg_ready,
    input  logic       pll_lock,
    output logic       pll_en,
    output logic [7:0] pll_fbdiv,
    output logic       ready,
    output logic       fault,
    output logic [7:0] relock_cnt,
    output logic [2:0] state
);
    localparam int CMAX = OFF_CYCLES > LOCK_TIMEOUT ? OFF_CYCLES : LOCK_TIMEOUT;
    localparam int CW = $clog2(CMAX + 1);
    localparam int RW = RETRY_MAX > 0 ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);
    localparam logic [CW-1:0] ACQ_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OFF    = 3'd1,
        ACQ    = 3'd2,
        LOCKED = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t st, st_n;
    logic [1:0] sync;
    logic lock_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [RW-1:0] retries, retries_n;
    logic [7:0] fbdiv_n, relock_n;

    assign lock_s = sync[1];
    assign state = st;
    assign pll_en = st == ACQ || st == LOCKED;
    assign ready = st == LOCKED;
    assign fault = st == FAULT;
    assign cfg_ready = st == IDLE || st == LOCKED || st == FAULT;

    always_comb begin
        st_n = st;
        cnt_n = cnt;
        retries_n = retries;
        fbdiv_n = pll_fbdiv;
        relock_n = relock_cnt;
        if (cfg_valid && cfg_ready) fbdiv_n = cfg_fbdiv == 8'd0 ? 8'd1 : cfg_fbdiv;
        if (st != IDLE && !start) begin
            st_n = IDLE;
        end else if (st == LOCKED && cfg_valid) begin
            // a divider change outranks a simultaneous lock loss, so no relock is counted
            st_n = OFF;
            cnt_n = '0;
            retries_n = '0;
        end else begin
            case (st)
                IDLE: if (start) begin
                    st_n = OFF;
                    cnt_n = '0;
                    retries_n = '0;
                end
                OFF: if (cnt == OFF_LAST) begin
                    st_n = ACQ;
                    cnt_n = '0;
                end else cnt_n = cnt + CW'(1);
                ACQ: if (lock_s) st_n = LOCKED;
                else if (cnt == ACQ_LAST) begin
                    if (retries < RMAX) begin
                        retries_n = retries + RW'(1);
                        st_n = OFF;
                        cnt_n = '0;
                    end else st_n = FAULT;
                end else cnt_n = cnt + CW'(1);
                LOCKED: if (!lock_s) begin
                    relock_n = relock_cnt == 8'hff ? relock_cnt : relock_cnt + 8'd1;
                    retries_n = '0;
                    st_n = OFF;
                    cnt_n = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            sync <= 2'b00;
            cnt <= '0;
            retries <= '0;
            pll_fbdiv <= FBDIV_RESET;
            relock_cnt <= 8'd0;
        end else begin
            st <= st_n;
            sync <= {sync[0], pll_lock};
            cnt <= cnt_n;
            retries <= retries_n;
            pll_fbdiv <= fbdiv_n;
            relock_cnt <= relock_n;
        end
    end
endmodule

// File: tb/tb_pll_seq_ctrl.sv
// tb_pll_seq_ctrl: scoreboard bench; expected output words are queued per cycle and compared after each edge
module tb_pll_seq_ctrl;
    localparam logic [2:0] S_IDLE = 3'd0, S_OFF = 3'd1, S_ACQ = 3'd2, S_LOCK = 3'd3, S_FAULT = 3'd4;

    logic rclk = 1'b0, rst = 1'b1, start = 1'b0, cfg_valid = 1'b0, pll_lock = 1'b0;
    logic [7:0] cfg_fbdiv = 8'd0;
    logic cfg_ready, pll_en, ready, fault;
    logic [7:0] pll_fbdiv, relock_cnt;
    logic [2:0] state;

    typedef struct {
        string tag;
        logic [22:0] v;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0, errors = 0;
    logic [7:0] efb = 8'd8, erl = 8'd0;

    pll_seq_ctrl #(.OFF_CYCLES(4), .LOCK_TIMEOUT(20), .RETRY_MAX(2), .FBDIV_RESET(8'd8)) dut (
        .rclk(rclk), .rst(rst), .start(start), .cfg_valid(cfg_valid), .cfg_fbdiv(cfg_fbdiv),
        .cfg_ready(cfg_ready), .pll_lock(pll_lock), .pll_en(pll_en), .pll_fbdiv(pll_fbdiv),
        .ready(ready), .fault(fault), .relock_cnt(relock_cnt), .state(state)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [22:0] pk(input logic [2:0] s, input logic [7:0] fb, input logic [7:0] rc);
        return {s, s == S_ACQ || s == S_LOCK, s == S_LOCK, s == S_FAULT,
                s == S_IDLE || s == S_LOCK || s == S_FAULT, fb, rc};
    endfunction

    always @(posedge rclk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check(e.tag, {9'd0, state, pll_en, ready, fault, cfg_ready, pll_fbdiv, relock_cnt}, {9'd0, e.v});
        end
    end

    task automatic run(input string tag, input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back('{tag, pk(s, efb, erl)});
            @(posedge rclk);
            #2;
        end
    endtask

    task automatic cfg(input string tag, input logic [2:0] s, input logic [7:0] fb, input logic [7:0] want);
        cfg_valid = 1'b1;
        cfg_fbdiv = fb;
        efb = want;
        run(tag, s, 1);
        cfg_valid = 1'b0;
    endtask

    task automatic drop(input string tag);
        pll_lock = 1'b0;
        run(tag, S_LOCK, 1);
        pll_lock = 1'b1;
        run(tag, S_LOCK, 1);
        erl = erl == 8'hff ? erl : erl + 8'd1;
        run(tag, S_OFF, 4);
        run(tag, S_ACQ, 1);
        run(tag, S_LOCK, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge rclk);
        #2;
        check("rst_state", state, S_IDLE);
        check("rst_en", pll_en, 0);
        check("rst_fbdiv", pll_fbdiv, 8);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_relock", relock_cnt, 0);
        rst = 1'b0;
        start = 1'b1;
        run("up_off", S_OFF, 4);
        run("up_acq", S_ACQ, 4);
        pll_lock = 1'b1;
        run("up_sync", S_ACQ, 2);
        run("up_lock", S_LOCK, 3);
        cfg("cfg16", S_OFF, 8'd16, 8'd16);
        run("cfg16_off", S_OFF, 3);
        run("cfg16_acq", S_ACQ, 1);
        run("cfg16_lock", S_LOCK, 1);
        cfg("cfg0", S_OFF, 8'd0, 8'd1);
        run("cfg0_off", S_OFF, 3);
        run("cfg0_acq", S_ACQ, 1);
        run("cfg0_lock", S_LOCK, 1);
        drop("drop1");
        pll_lock = 1'b0;
        run("cfg_drop", S_LOCK, 2);
        cfg("cfg_drop", S_OFF, 8'h22, 8'h22);
        pll_lock = 1'b1;
        run("cfg_drop_off", S_OFF, 3);
        run("cfg_drop_acq", S_ACQ, 1);
        run("cfg_drop_lock", S_LOCK, 1);
        for (int i = 0; i < 299; i++) drop("drop_sat");
        start = 1'b0;
        pll_lock = 1'b0;
        run("stop_lock", S_IDLE, 3);
        start = 1'b1;
        run("abort_off", S_OFF, 4);
        run("abort_acq", S_ACQ, 7);
        start = 1'b0;
        run("abort", S_IDLE, 1);
        start = 1'b1;
        for (int a = 0; a < 3; a++) begin
            run("to_off", S_OFF, 4);
            run("to_acq", S_ACQ, 20);
        end
        run("fault", S_FAULT, 3);
        cfg("cfg_fault", S_FAULT, 8'h33, 8'h33);
        start = 1'b0;
        run("fault_clr", S_IDLE, 1);
        start = 1'b1;
        pll_lock = 1'b1;
        run("re_off", S_OFF, 4);
        run("re_acq", S_ACQ, 1);
        run("re_lock", S_LOCK, 1);
        start = 1'b0;
        cfg("cfg_stop", S_IDLE, 8'h44, 8'h44);
        start = 1'b1;
        run("re2_off", S_OFF, 4);
        run("re2_acq", S_ACQ, 1);
        run("re2_lock", S_LOCK, 1);
        check("queue_empty", q.size(), 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", state, S_IDLE);
        check("arst_en", pll_en, 0);
        check("arst_ready", ready, 0);
        check("arst_fault", fault, 0);
        check("arst_cfg_ready", cfg_ready, 1);
        check("arst_fbdiv", pll_fbdiv, 8);
        check("arst_relock", relock_cnt, 0);
        #10;
        rst = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
